// File: rtl/sync_fifo_rd_stream_adapter.sv
// Read-side adapter: SRAM FIFO pop port -> valid/ready stream via credit-based skid buffer.
// Optional saturating stall counter enabled by SYNC_FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN.
module sync_fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = RD_LATENCY + 1,
    parameter int CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  buf_count
`ifdef SYNC_FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int SW = CNT_WIDTH + 1;

    logic [RD_LATENCY-1:0] inflight;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic [SW-1:0]         n_inflight;
    logic [SW-1:0]         credit;
    logic                  arrive;
    logic                  pop_out;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign arrive    = inflight[RD_LATENCY-1];
    assign pop_out   = out_valid & out_ready;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign buf_count = count;

    // Count words already requested from the FIFO but not yet captured.
    always_comb begin
        n_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            n_inflight = n_inflight + SW'(inflight[i]);
        end
    end

    // Buffered plus in-flight words after this cycle's pop must leave room for one more.
    assign credit     = {1'b0, count} + n_inflight - SW'(pop_out);
    assign fifo_rd_en = rst_n & ~fifo_empty & (credit < SW'(BUF_DEPTH));

    // Track outstanding reads; a cleared register makes stale FIFO data harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight <= (inflight << 1) | RD_LATENCY'(fifo_rd_en);
        end
    end

    // Skid buffer storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (arrive) begin
                mem[wr_ptr] <= fifo_dout;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_out) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({arrive, pop_out})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
    // Saturating count of cycles where data waits on the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_rd_stream_adapter.sv
// Bench: two adapters (read latency 1 and 2) fed by behavioural SRAM FIFOs,
// scoreboarded stream output, stall and reset scenarios.
module tb_sync_fifo_rd_stream_adapter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rd_en0, empty0 = 1'b1, ovalid0, or0 = 1'b0;
    logic [15:0] dout0 = '0, odata0;
    logic [1:0]  bcnt0;
    logic        rd_en1, empty1 = 1'b1, ovalid1, or1 = 1'b0;
    logic [15:0] s1 = '0, dout1 = '0, odata1;
    logic [1:0]  bcnt1;
`ifdef SYNC_FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
    logic [15:0] stall0, stall1;
`endif

    logic [15:0] fq0[$], fq1[$], sb0[$], sb1[$];
    int n_cmp = 0, n_err = 0;
    int beats0 = 0, beats1 = 0, rdp0 = 0, peak1 = 0;

    sync_fifo_rd_stream_adapter #(.DATA_WIDTH(16), .RD_LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .fifo_rd_en(rd_en0), .fifo_dout(dout0),
        .fifo_empty(empty0), .out_valid(ovalid0), .out_data(odata0),
        .out_ready(or0), .buf_count(bcnt0)
`ifdef SYNC_FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
        , .stall_cnt(stall0)
`endif
    );

    sync_fifo_rd_stream_adapter #(.DATA_WIDTH(16), .RD_LATENCY(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_rd_en(rd_en1), .fifo_dout(dout1),
        .fifo_empty(empty1), .out_valid(ovalid1), .out_data(odata1),
        .out_ready(or1), .buf_count(bcnt1)
`ifdef SYNC_FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
        , .stall_cnt(stall1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [15:0] d);
        fq0.push_back(d);
        sb0.push_back(d);
    endtask

    task automatic push1(input logic [15:0] d);
        fq1.push_back(d);
        sb1.push_back(d);
    endtask

    // FIFO model, read latency 1, registered empty flag
    always @(posedge clk) begin
        if (!rst_n) begin
            fq0.delete();
            empty0 <= 1'b1;
        end else begin
            if (rd_en0 && fq0.size() != 0) dout0 <= fq0.pop_front();
            empty0 <= (fq0.size() == 0);
        end
    end

    // FIFO model, read latency 2
    always @(posedge clk) begin
        if (!rst_n) begin
            fq1.delete();
            empty1 <= 1'b1;
        end else begin
            if (rd_en1 && fq1.size() != 0) s1 <= fq1.pop_front();
            empty1 <= (fq1.size() == 0);
        end
        dout1 <= s1;
    end

    // Stream monitors: scoreboard, hold stability, issue legality
    logic        pv0 = 1'b0, pr0 = 1'b0, pv1 = 1'b0, pr1 = 1'b0;
    logic [15:0] pd0 = '0, pd1 = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_while_empty0", rd_en0 & empty0, 1'b0);
            chk("rd_while_empty1", rd_en1 & empty1, 1'b0);
            chk("bcnt_max0", bcnt0 > 2'd2, 1'b0);
            chk("bcnt_max1", bcnt1 > 2'd3, 1'b0);
            if (!or0 && bcnt0 == 2'd2) chk("full_stall0", rd_en0, 1'b0);
            if (!or1 && bcnt1 == 2'd3) chk("full_stall1", rd_en1, 1'b0);
            if (rd_en0) rdp0++;
            if (int'(bcnt1) > peak1) peak1 = int'(bcnt1);
            if (pv0 && !pr0) begin
                chk("hold_valid0", ovalid0, 1'b1);
                chk("hold_data0", odata0, pd0);
            end
            if (pv1 && !pr1) begin
                chk("hold_valid1", ovalid1, 1'b1);
                chk("hold_data1", odata1, pd1);
            end
            if (ovalid0 && or0) begin
                beats0++;
                if (sb0.size() == 0) chk("extra_beat0", odata0, 32'hDEAD);
                else chk("data0", odata0, sb0.pop_front());
            end
            if (ovalid1 && or1) begin
                beats1++;
                if (sb1.size() == 0) chk("extra_beat1", odata1, 32'hDEAD);
                else chk("data1", odata1, sb1.pop_front());
            end
        end
        pv0 = rst_n & ovalid0;
        pr0 = or0;
        pd0 = odata0;
        pv1 = rst_n & ovalid1;
        pr1 = or1;
        pd1 = odata1;
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_rd0"}, rd_en0, 1'b0);
        chk({tag, "_v0"}, ovalid0, 1'b0);
        chk({tag, "_d0"}, odata0, 16'h0);
        chk({tag, "_cnt0"}, bcnt0, 2'd0);
        chk({tag, "_rd1"}, rd_en1, 1'b0);
        chk({tag, "_v1"}, ovalid1, 1'b0);
        chk({tag, "_d1"}, odata1, 16'h0);
        chk({tag, "_cnt1"}, bcnt1, 2'd0);
`ifdef SYNC_FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
        chk({tag, "_stall0"}, stall0, 16'h0);
        chk({tag, "_stall1"}, stall1, 16'h0);
`endif
    endtask

    initial begin
        int te, tv, tl, nv;

        // reset state
        tick(3);
        @(negedge clk);
        chk_zero("reset");
        tick();
        rst_n = 1'b1;

        // full-rate stream, latency 1
        or0 = 1'b1;
        for (int i = 1; i <= 8; i++) push0(16'(i));
        te = -1; tv = -1; tl = -1; nv = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (te < 0 && !empty0) te = k;
            if (ovalid0) begin
                if (tv < 0) tv = k;
                tl = k;
                nv++;
            end
        end
        chk("t1_latency", tv - te, 2);
        chk("t1_beats", nv, 8);
        chk("t1_no_gaps", tl - tv + 1, 8);
        chk("t1_drained", sb0.size(), 0);
        tick();

        // backpressure, latency 2
        beats1 = 0; peak1 = 0;
        or1 = 1'b1;
        for (int i = 0; i < 10; i++) push1(16'h0100 + 16'(i));
        for (int k = 0; k < 50 && beats1 < 3; k++) tick();
        or1 = 1'b0;
        tick(5);
        or1 = 1'b1;
        for (int k = 0; k < 100 && sb1.size() != 0; k++) tick();
        tick(3);
        chk("t2_peak", peak1, 3);
        chk("t2_beats", beats1, 10);
        chk("t2_drained", sb1.size(), 0);

        // single word
        rdp0 = 0; beats0 = 0;
        or0 = 1'b1;
        push0(16'hA5A5);
        tick(10);
        chk("t3_rd_pulses", rdp0, 1);
        chk("t3_beats", beats0, 1);
        chk("t3_drained", sb0.size(), 0);

        // random backpressure with wrap-around, both latencies
        beats0 = 0; beats1 = 0;
        for (int i = 0; i < 50; i++) begin
            push0(16'h2000 + 16'(i));
            push1(16'h3000 + 16'(i));
        end
        for (int k = 0; k < 3000 && (sb0.size() != 0 || sb1.size() != 0); k++) begin
            or0 = 1'($urandom_range(0, 1));
            or1 = 1'($urandom_range(0, 1));
            tick();
        end
        or0 = 1'b1; or1 = 1'b1;
        tick(4);
        chk("t4_beats0", beats0, 50);
        chk("t4_beats1", beats1, 50);
        chk("t4_drained", sb0.size() + sb1.size(), 0);

        // reset with two reads in flight
        for (int i = 0; i < 6; i++) push1(16'h4000 + 16'(i));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!empty1) break;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb0.delete();
        sb1.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        beats1 = 0;
        tick(10);
        chk("t5_no_stale", beats1, 0);
        push1(16'h5151);
        push1(16'h5252);
        tick(10);
        chk("t5_post_beats", beats1, 2);
        chk("t5_drained", sb1.size(), 0);

`ifdef SYNC_FIFO_RD_STREAM_ADAPTER_STALL_CNT_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        or0 = 1'b0;
        push0(16'h5A5A);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ovalid0) break;
        end
        chk("t6_start", stall0, 16'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t6_stall20", stall0, 16'd20);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("t6_saturate", stall0, 16'hFFFF);
        chk("t6_idle1", stall1, 16'd0);
        #1;
        or0 = 1'b1;
        tick(5);
        chk("t6_drained", sb0.size(), 0);
`endif

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
